// File: rtl/md_pkg.sv
// Shared definitions for the multdiv stall controller: FSM state encoding and default timeout.
package md_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MD_TIMEOUT_DEFAULT = 64;
    localparam int MD_CNT_W_DEFAULT   = 7;

endpackage

// File: rtl/dffe_ref.sv
// Reference enabled flip-flop bank with asynchronous active-high clear.
module dffe_ref #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             en,
    input  logic             clr
);

    // Storage: clear wins asynchronously, otherwise load on enable.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/md_busy_counter.sv
// Busy-cycle counter: synchronous clear, increment, saturation at all-ones.
module md_busy_counter
    import md_pkg::*;
#(
    parameter int CNT_W = MD_CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_nxt_s;
    logic             cnt_en_s;

    // Next count: clear beats increment; increment stops at CNT_MAX.
    always_comb begin
        cnt_nxt_s = cnt;
        cnt_en_s  = 1'b0;
        if (clr) begin
            cnt_nxt_s = '0;
            cnt_en_s  = 1'b1;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt_nxt_s = cnt + CNT_W'(1);
            cnt_en_s  = 1'b1;
        end else begin
            cnt_nxt_s = cnt;
            cnt_en_s  = 1'b0;
        end
    end

    dffe_ref #(.WIDTH(CNT_W)) u_cnt_reg (
        .q   (cnt),
        .d   (cnt_nxt_s),
        .clk (clock),
        .en  (cnt_en_s),
        .clr (~reset_n)
    );

endmodule

// File: rtl/md_stall_ctrl.sv
// Pipeline stall controller for the iterative multdiv unit: start pulses, DX stall, XM bubble/result steering.
module md_stall_ctrl
    import md_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MD_TIMEOUT_DEFAULT,
    parameter int CNT_W          = MD_CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             dx_is_mul,
    input  logic             dx_is_div,
    input  logic             md_ready,
    input  logic             md_exception,
    output logic             ctrl_mult,
    output logic             ctrl_div,
    output logic             stall,
    output logic             xm_bubble,
    output logic             xm_sel_md,
    output logic             xm_ovf,
    output logic [CNT_W-1:0] busy_cnt
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    md_state_e state_r;
    md_state_e state_nxt_s;
    logic      state_q_s;
    logic      cnt_clr_s;
    logic      cnt_inc_s;

    assign state_r = md_state_e'(state_q_s);

    // Next state and all combinational outputs; start pulses depend only on state and DX decode.
    always_comb begin
        state_nxt_s = state_r;
        ctrl_mult   = 1'b0;
        ctrl_div    = 1'b0;
        stall       = 1'b0;
        xm_bubble   = 1'b0;
        xm_sel_md   = 1'b0;
        xm_ovf      = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dx_is_mul || dx_is_div) begin
                    ctrl_mult   = dx_is_mul;
                    ctrl_div    = dx_is_div & ~dx_is_mul;
                    stall       = 1'b1;
                    xm_bubble   = 1'b1;
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (md_ready) begin
                    xm_sel_md   = 1'b1;
                    xm_ovf      = md_exception;
                    state_nxt_s = ST_IDLE;
                end else if (busy_cnt >= TIMEOUT_LAST) begin
                    // Unit never answered: release the pipeline with an error result.
                    xm_sel_md   = 1'b1;
                    xm_ovf      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    stall       = 1'b1;
                    xm_bubble   = 1'b1;
                    cnt_inc_s   = 1'b1;
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    dffe_ref #(.WIDTH(1)) u_state_reg (
        .q   (state_q_s),
        .d   (state_nxt_s),
        .clk (clock),
        .en  (1'b1),
        .clr (~reset_n)
    );

    md_busy_counter #(.CNT_W(CNT_W)) u_busy_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (cnt_clr_s),
        .inc     (cnt_inc_s),
        .cnt     (busy_cnt)
    );

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Scoreboard bench for md_stall_ctrl: directed per-cycle vectors queued by stimulus, checked by a negedge monitor.
module tb_md_stall_ctrl;

    logic       clock;
    logic       reset_n;
    logic       dx_is_mul;
    logic       dx_is_div;
    logic       md_ready;
    logic       md_exception;
    logic       ctrl_mult;
    logic       ctrl_div;
    logic       stall;
    logic       xm_bubble;
    logic       xm_sel_md;
    logic       xm_ovf;
    logic [6:0] busy_cnt;

    typedef struct {
        logic [12:0] v;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_err;

    md_stall_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .dx_is_mul    (dx_is_mul),
        .dx_is_div    (dx_is_div),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .stall        (stall),
        .xm_bubble    (xm_bubble),
        .xm_sel_md    (xm_sel_md),
        .xm_ovf       (xm_ovf),
        .busy_cnt     (busy_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {ctrl_mult, ctrl_div, stall, xm_bubble, xm_sel_md, xm_ovf, busy_cnt}
    function automatic logic [12:0] pk(input logic cm, input logic cd, input logic st,
                                       input logic bb, input logic sel, input logic ovf,
                                       input int c);
        return {cm, cd, st, bb, sel, ovf, 7'(c)};
    endfunction

    // Apply one cycle of inputs just after the rising edge and queue the expected outputs.
    task automatic step(input logic rn, input logic m, input logic d, input logic r,
                        input logic e, input logic [12:0] x, input string nm);
        @(posedge clock);
        #1;
        reset_n      = rn;
        dx_is_mul    = m;
        dx_is_div    = d;
        md_ready     = r;
        md_exception = e;
        exp_q.push_back('{v: x, nm: nm});
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    initial begin
        exp_t        e;
        logic [12:0] act;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {ctrl_mult, ctrl_div, stall, xm_bubble, xm_sel_md, xm_ovf, busy_cnt};
                n_cmp++;
                if (act !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got {cm,cd,st,bb,sel,ovf,cnt}=%b_%0d required %b_%0d",
                             e.nm, act[12:7], act[6:0], e.v[12:7], e.v[6:0]);
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        dx_is_mul = 1'b0;
        dx_is_div = 1'b0;
        md_ready = 1'b0;
        md_exception = 1'b0;

        // Reset state, then idle with and without stray md_ready
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pk(0,0,0,0,0,0,0), "reset_state");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(0,0,0,0,0,0,0), "post_reset_idle");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pk(0,0,0,0,0,0,0), "idle_ready_ignored");

        // Multiply: result on the 33rd cycle after the start cycle
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(1,0,1,1,0,0,0), "mul_start");
        for (int i = 0; i < 32; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(0,0,1,1,0,0,i), "mul_busy");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, pk(0,0,0,0,1,0,32), "mul_done");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(0,0,0,0,0,0,32), "mul_idle_hold");

        // Divide with exception after 5 busy cycles
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(0,1,1,1,0,0,32), "div_start");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(0,0,1,1,0,0,i), "div_busy");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, pk(0,0,0,0,1,1,5), "div_exc_done");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(0,0,0,0,0,0,5), "div_idle");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, pk(0,0,0,0,0,0,5), "idle_ready_ignored2");

        // Divide that never answers: forced completion at busy_cnt = 63
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(0,1,1,1,0,0,5), "to_start");
        for (int i = 0; i < 63; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(0,0,1,1,0,0,i), "to_busy");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(0,0,0,0,1,1,63), "to_forced");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(0,0,0,0,0,0,63), "to_idle");

        // Back-to-back: mul completes, div starts the very next cycle
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(1,0,1,1,0,0,63), "b2b_mul_start");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(0,0,1,1,0,0,i), "b2b_mul_busy");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, pk(0,0,0,0,1,0,3), "b2b_mul_done");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(0,1,1,1,0,0,3), "b2b_div_start");
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(0,0,1,1,0,0,i), "b2b_div_busy");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(0,0,0,0,1,0,2), "b2b_div_done");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(0,0,0,0,0,0,2), "b2b_idle");

        // Both decodes set: mul wins
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, pk(1,0,1,1,0,0,2), "both_start");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, pk(0,0,1,1,0,0,0), "both_busy");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pk(0,0,0,0,1,0,1), "both_done");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(0,0,0,0,0,0,1), "both_idle");

        // Reset during BUSY cycle 10 clears asynchronously; later md_ready ignored
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(1,0,1,1,0,0,1), "rst_mul_start");
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(0,0,1,1,0,0,i), "rst_busy");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pk(0,0,0,0,0,0,0), "rst_async_clear");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, pk(0,0,0,0,0,0,0), "rst_late_ready");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pk(0,0,0,0,0,0,0), "rst_late_ready2");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clock);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        if (n_cmp < 12) begin
            n_err++;
            $display("FAIL cmp_count: got %0d comparisons, required at least 12", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
